// File: rtl/merge_pkg.sv
// Shared types and constants for the sum/difference merge and split stages.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package merge_pkg;

   localparam int MERGE_W = 32;

   // Word tag on the merged channel
   localparam logic SEL_SUM  = 1'b1;
   localparam logic SEL_DIFF = 1'b0;

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      HAVE_SUM  = 2'd1,
      HAVE_DIFF = 2'd2
   } ms_state_t;

endpackage

// File: rtl/merge_recover.sv
// Recovers operands a and b from an untruncated sum word and a two's-complement difference word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module merge_recover
   import merge_pkg::*;
#(
   parameter int W = MERGE_W
) (
   input  logic [W:0]   s,
   input  logic [W:0]   d,
   output logic [W-1:0] opa,
   output logic [W-1:0] opb,
   output logic         err
);

   // Bits [W:0] of the sign-extended sum equal the plain (W+1)-bit sum, and
   // only those bits are consumed, so the extra top bit is never formed.
   logic [W:0] t;

   // t = s + d = 2a; halve for a, subtract from s for b, odd t flags a bad pair
   always_comb begin
      t   = s + d;
      opa = t[W:1];
      opb = s[W-1:0] - t[W:1];
      err = t[0];
   end

endmodule

// File: rtl/merge_split.sv
// Pairs tagged sum/difference words and emits the recovered operands on a registered channel.
// Latency: pair visible on out_* the cycle after the completing word is accepted.
// Backpressure: in_ready = !out_valid || out_ready; nothing is accepted while a pair is stalled.
module merge_split
   import merge_pkg::*;
#(
   parameter int W     = MERGE_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [W:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_opa,
   output logic [W-1:0]     out_opb,
   output logic             out_err,
   output logic [CNT_W-1:0] pair_cnt
);

   ms_state_t  state_q, state_d;
   logic [W:0] s_q, s_d, d_q, d_d;
   logic [W:0] rec_s, rec_d;
   logic [W-1:0] rec_opa, rec_opb;
   logic       rec_err;
   logic       accept;
   logic       load_out;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Next state, held-word updates and pair completion; the incoming word
   // stands in for whichever half is not already held.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      d_d      = d_q;
      load_out = 1'b0;
      rec_s    = (state_q == HAVE_DIFF) ? in_data : s_q;
      rec_d    = (state_q == HAVE_SUM)  ? in_data : d_q;
      if (accept) begin
         case (state_q)
            EMPTY: begin
               if (in_sel == SEL_SUM) begin
                  s_d     = in_data;
                  state_d = HAVE_SUM;
               end else begin
                  d_d     = in_data;
                  state_d = HAVE_DIFF;
               end
            end
            HAVE_SUM: begin
               if (in_sel == SEL_SUM) begin
                  s_d = in_data;          // duplicate tag: newest word wins
               end else begin
                  load_out = 1'b1;
                  state_d  = EMPTY;
               end
            end
            HAVE_DIFF: begin
               if (in_sel == SEL_DIFF) begin
                  d_d = in_data;          // duplicate tag: newest word wins
               end else begin
                  load_out = 1'b1;
                  state_d  = EMPTY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   merge_recover #(.W(W)) u_recover (
      .s   (rec_s),
      .d   (rec_d),
      .opa (rec_opa),
      .opb (rec_opb),
      .err (rec_err)
   );

   // FSM state and held half-pair registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         s_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         d_q     <= d_d;
      end
   end

   // One-entry output register: reload on completion, else clear on drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_opa   <= '0;
         out_opb   <= '0;
         out_err   <= 1'b0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_opa   <= rec_opa;
         out_opb   <= rec_opb;
         out_err   <= rec_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Count delivered pairs, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_cnt <= '0;
      end else if (out_valid && out_ready) begin
         pair_cnt <= pair_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_merge_split.sv
// Bench for merge_split: directed vector table, hand sequences, and random traffic vs a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_merge_split;
   import merge_pkg::*;

   localparam int W     = 32;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [W:0]       in_data;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_opa;
   logic [W-1:0]     out_opb;
   logic             out_err;
   logic [CNT_W-1:0] pair_cnt;

   merge_split #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_opa   (out_opa),
      .out_opb   (out_opb),
      .out_err   (out_err),
      .pair_cnt  (pair_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;
   int exp_cnt  = 0;

   typedef struct {
      logic        sel1;
      logic [32:0] w1;
      logic [32:0] w2;
      logic [31:0] opa;
      logic [31:0] opb;
      logic        err;
   } vec_t;

   vec_t vecs[6];

   // random-phase model state
   logic [64:0] expq[$];
   logic [32:0] held;
   logic        held_sel;
   bit          have_held;
   int          hs_cnt;
   logic [31:0] ra, rb;
   logic [32:0] wd;
   logic [31:0] keep_opa, keep_opb;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until accepted (bounded wait)
   task automatic send(input logic sel, input logic [W:0] data);
      int n;
      in_sel   = sel;
      in_data  = data;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) begin
         total++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt++;
   endtask

   // Reference: treat words as signed integers, t = s + d, a = t/2, b = s - a
   function automatic logic [64:0] ref_pair(input logic [32:0] s, input logic [32:0] d);
      longint      t;
      logic [31:0] a, b;
      logic        e;
      t = longint'($signed(s)) + longint'($signed(d));
      a = 32'(t >>> 1);
      b = s[31:0] - a;
      e = t[0];
      return {a, b, e};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 33'd10,           33'd4,            32'd7,          32'd3,          1'b0};
      vecs[1] = '{1'b0, 33'h1_0000_0003,  33'h1_0000_0001,  32'd2,          32'hFFFF_FFFF,  1'b0};
      vecs[2] = '{1'b1, 33'd5,            33'd2,            32'd3,          32'd2,          1'b1};
      vecs[3] = '{1'b1, 33'd0,            33'd0,            32'd0,          32'd0,          1'b0};
      vecs[4] = '{1'b1, 33'h1_FFFF_FFFE,  33'd0,            32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0};
      vecs[5] = '{1'b0, 33'h1_8000_0000,  33'h0_8000_0000,  32'd0,          32'h8000_0000,  1'b0};

      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_opa",   out_opa,   32'd0);
      chk("rst_out_opb",   out_opb,   32'd0);
      chk("rst_out_err",   out_err,   1'b0);
      chk("rst_pair_cnt",  pair_cnt,  16'd0);
      chk("rst_in_ready",  in_ready,  1'b1);

      // table of complete pairs, either word order
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].sel1, vecs[i].w1);
         chk($sformatf("vec%0d_half_valid", i), out_valid, 1'b0);
         send(!vecs[i].sel1, vecs[i].w2);
         chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("vec%0d_opa", i),   out_opa,   vecs[i].opa);
         chk($sformatf("vec%0d_opb", i),   out_opb,   vecs[i].opb);
         chk($sformatf("vec%0d_err", i),   out_err,   vecs[i].err);
         drain();
         chk($sformatf("vec%0d_cnt", i),   pair_cnt,  16'(exp_cnt));
         chk($sformatf("vec%0d_empty", i), out_valid, 1'b0);
      end

      // duplicate tag: the later sum replaces the earlier one
      send(SEL_SUM, 33'd10);
      send(SEL_SUM, 33'd20);
      chk("dup_no_pair", out_valid, 1'b0);
      send(SEL_DIFF, 33'd0);
      chk("dup_opa", out_opa, 32'd10);
      chk("dup_opb", out_opb, 32'd10);
      chk("dup_err", out_err, 1'b0);
      drain();
      tick(); tick();
      chk("dup_one_pair_valid", out_valid, 1'b0);
      chk("dup_one_pair_cnt",   pair_cnt,  16'(exp_cnt));

      // backpressure: stall first pair, second pair waiting at the input
      send(SEL_SUM, 33'd10);
      send(SEL_DIFF, 33'd4);
      keep_opa = out_opa;
      keep_opb = out_opb;
      in_sel = SEL_SUM; in_data = 33'd30; in_valid = 1'b1;
      tick(); tick(); tick();
      chk("bp_in_ready",  in_ready,  1'b0);
      chk("bp_valid",     out_valid, 1'b1);
      chk("bp_opa_hold",  out_opa,   32'd7);
      chk("bp_opb_hold",  out_opb,   32'd3);
      chk("bp_stable",    {out_opa, out_opb}, {keep_opa, keep_opb});
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", in_ready, 1'b1);
      tick();
      exp_cnt++;
      in_sel = SEL_DIFF; in_data = 33'd10;
      chk("bp_next_rdy", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("bp2_valid", out_valid, 1'b1);
      chk("bp2_opa",   out_opa,   32'd20);
      chk("bp2_opb",   out_opb,   32'd10);
      drain();
      chk("bp_cnt_both", pair_cnt, 16'(exp_cnt));

      // reset with a lone sum held: it must be forgotten
      send(SEL_SUM, 33'd10);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      exp_cnt = 0;
      chk("mid_rst_cnt",   pair_cnt,  16'd0);
      chk("mid_rst_valid", out_valid, 1'b0);
      tick();
      send(SEL_DIFF, 33'd4);
      chk("mid_rst_fresh", out_valid, 1'b0);
      send(SEL_SUM, 33'd10);
      chk("mid_rst_opa", out_opa, 32'd7);
      chk("mid_rst_opb", out_opb, 32'd3);
      drain();
      chk("mid_rst_cnt1", pair_cnt, 16'd1);

      // random traffic against the model
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      have_held = 1'b0;
      held = '0;
      held_sel = 1'b0;
      hs_cnt = 0;
      expq.delete();
      ra = $urandom;
      rb = $urandom;
      for (int c = 0; c < 3000; c++) begin
         if (c < 2900) in_valid = ($urandom_range(0, 3) != 0);
         else          in_valid = 1'b0;
         in_sel = 1'($urandom_range(0, 1));
         if (!have_held) begin
            ra = $urandom;
            rb = $urandom;
         end
         wd = in_sel ? ({1'b0, ra} + {1'b0, rb}) : ({1'b0, ra} - {1'b0, rb});
         if ($urandom_range(0, 7) == 0) wd[0] = ~wd[0];
         if ($urandom_range(0, 15) == 0) wd = {1'($urandom_range(0, 1)), 32'($urandom)};
         in_data = wd;
         out_ready = (c >= 2900) || ($urandom_range(0, 2) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               total++;
               $display("FAIL rand_unexpected: got pair %0h/%0h, expected no pair", out_opa, out_opb);
            end else begin
               chk($sformatf("rand_pair%0d", hs_cnt), {out_opa, out_opb, out_err}, expq.pop_front());
            end
            hs_cnt++;
         end
         if (in_valid && in_ready) begin
            if (have_held && held_sel != in_sel) begin
               if (in_sel == SEL_SUM) expq.push_back(ref_pair(in_data, held));
               else                   expq.push_back(ref_pair(held, in_data));
               have_held = 1'b0;
            end else begin
               held      = in_data;
               held_sel  = in_sel;
               have_held = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("rand_leftover", expq.size(), 0);
      chk("rand_cnt", pair_cnt, 16'(hs_cnt));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
